// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and helpers for the inst SRAM responder.
// The optional per-byte parity store is enabled by defining INST_SRAM_PARITY_EN.
package inst_sram_responder_pkg;

  localparam int          INST_SRAM_ADDR_W = 12;
  localparam logic [31:0] INST_SRAM_BASE   = 32'h1c000000;
  localparam logic [31:0] LA_NOP           = 32'h03400000;

  // Upper address bits above the array window must match the base.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          aw);
    return (addr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffffffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// Inst SRAM request/response bundle between the fetch stage (master) and responder (slave).
interface inst_sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        resp_valid;
  logic        addr_err;
  logic        par_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata, resp_valid, addr_err, par_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata, resp_valid, addr_err, par_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/inst_sram_responder_byte_lane.sv
// One byte lane of the inst SRAM: read-first, registered output, optional parity bit
// (INST_SRAM_PARITY_EN). Array contents are never reset; only the output register is.
module inst_sram_responder_byte_lane #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              perr
);

`ifdef INST_SRAM_PARITY_EN
  localparam int W = 9;
  logic [W-1:0] wword;
  assign wword = {^wdata, wdata};
`else
  localparam int W = 8;
  logic [W-1:0] wword;
  assign wword = wdata;
`endif

  logic [W-1:0] mem [2**ADDR_W];
  logic [W-1:0] q;

  always_ff @(posedge clk)
    if (en && we) mem[idx] <= wword;

  // q only moves on an accepted access, so it holds through idle cycles.
  always_ff @(posedge clk)
    if (reset)   q <= '0;
    else if (en) q <= mem[idx];

  assign rdata = q[7:0];

`ifdef INST_SRAM_PARITY_EN
  assign perr = q[8] ^ (^q[7:0]);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/inst_sram_responder.sv
// Inst SRAM responder: 4 byte lanes, range/alignment check, 1-cycle response, counters.
// Define INST_SRAM_PARITY_EN to store and check even parity per byte.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int          ADDR_W   = INST_SRAM_ADDR_W,
  parameter logic [31:0] BASE     = INST_SRAM_BASE,
  parameter logic [31:0] OOR_DATA = LA_NOP
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_sram_responder_if.slave bus
);

  logic              acc, in_range, is_rd, misalign;
  logic [ADDR_W-1:0] idx;
  logic [3:0][7:0]   lane_q;
  logic [3:0]        lane_perr;

  logic              oor_q, rd_ok_q, resp_valid_q, addr_err_q;
  logic [31:0]       rd_cnt_q, wr_cnt_q;

  assign acc      = bus.sram_en & ~reset;
  assign in_range = addr_in_range(bus.sram_addr, BASE, ADDR_W);
  assign is_rd    = (bus.sram_wen == 4'h0);
  assign misalign = (bus.sram_addr[1:0] != 2'b00);
  assign idx      = bus.sram_addr[ADDR_W+1:2];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    inst_sram_responder_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (acc & in_range),
      .we    (bus.sram_wen[i]),
      .idx   (idx),
      .wdata (bus.sram_wdata[8*i +: 8]),
      .rdata (lane_q[i]),
      .perr  (lane_perr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oor_q        <= 1'b0;
      rd_ok_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      resp_valid_q <= acc & is_rd;
      addr_err_q   <= acc & (~in_range | misalign);
      // Response source flags follow the last accepted access and hold while idle.
      if (acc) begin
        oor_q   <= ~in_range;
        rd_ok_q <= in_range & is_rd;
      end
      if (acc && in_range && is_rd)  rd_cnt_q <= sat_inc(rd_cnt_q);
      if (acc && in_range && !is_rd) wr_cnt_q <= sat_inc(wr_cnt_q);
    end
  end

  assign bus.sram_rdata = oor_q ? OOR_DATA : lane_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.par_err    = rd_ok_q & (|lane_perr);
  assign bus.rd_cnt     = rd_cnt_q;
  assign bus.wr_cnt     = wr_cnt_q;

endmodule
